// File: rtl/sram_l0_if.sv
// Bus between the L0 loader and its surroundings: start/length request, SRAM read
// port, L0 write port, status, and debug visibility of the FSM and skid buffer.
interface sram_l0_if #(
    parameter int ADDR_BW = 7,
    parameter int DATA_BW = 32,
    parameter int LEN_BW  = 8
) ();
    logic               start;
    logic [ADDR_BW-1:0] base_addr;
    logic [LEN_BW-1:0]  len;
    logic               sram_cen;
    logic               sram_wen;
    logic [ADDR_BW-1:0] sram_a;
    logic [DATA_BW-1:0] sram_q;
    logic               l0_full;
    logic               l0_wr;
    logic [DATA_BW-1:0] l0_in;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;
    logic [1:0]         dbg_occ;

    // Handshake: a word moves into L0 on every rising edge where l0_wr=1, and
    // l0_wr is only raised while l0_full=0 in the same cycle.
    modport slave (
        input  start, base_addr, len, sram_q, l0_full,
        output sram_cen, sram_wen, sram_a, l0_wr, l0_in, busy, done, dbg_state, dbg_occ
    );

    modport master (
        output start, base_addr, len, sram_q, l0_full,
        input  sram_cen, sram_wen, sram_a, l0_wr, l0_in, busy, done, dbg_state, dbg_occ
    );
endinterface

// File: rtl/sram_l0_loader.sv
// Streams len consecutive SRAM words (address wraps mod 128) into L0, using a
// 2-entry skid buffer to absorb the one-cycle SRAM read latency under backpressure.
module sram_l0_loader #(
    parameter int ADDR_BW = 7,
    parameter int DATA_BW = 32,
    parameter int LEN_BW  = 8
) (
    input  logic       clk,
    input  logic       reset,
    sram_l0_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [ADDR_BW-1:0] addr_q, addr_d;
    logic [ADDR_BW-1:0] sram_a_q, sram_a_d;
    logic [LEN_BW-1:0]  rem_q, rem_d;
    logic               rf_q;
    logic [1:0]         occ_q, occ_d;
    logic [DATA_BW-1:0] buf_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic               issue, pop, push;

    assign pop  = (state_q == S_RUN) && (occ_q != 2'd0) && !bus.l0_full;
    assign push = rf_q;
    // A read is issued only if its data will still fit once it lands next cycle.
    assign issue = (state_q == S_RUN) && (rem_q != '0) &&
                   (({1'b0, occ_q} + {2'b0, rf_q} - {2'b0, pop}) <= 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final pop and the DONE transition share an edge, so done lands one cycle after the last write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = (bus.len == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if ((rem_q == '0) && !rf_q &&
                    ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if ((state_q == S_IDLE) && bus.start) begin
            addr_d = bus.base_addr;
            rem_d  = bus.len;
        end else if (issue) begin
            addr_d = addr_q + ADDR_BW'(1);
            rem_d  = rem_q - LEN_BW'(1);
        end
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        sram_a_d = issue ? addr_q : sram_a_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            rem_q    <= '0;
            sram_a_q <= '0;
            rf_q     <= 1'b0;
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            sram_a_q <= sram_a_d;
            rf_q     <= issue;
            occ_q    <= occ_d;
            if (push) begin
                buf_q[wr_ptr_q] <= bus.sram_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_comb begin
        bus.sram_cen  = ~issue;
        bus.sram_wen  = 1'b1;
        bus.sram_a    = sram_a_d;
        bus.l0_wr     = pop;
        bus.l0_in     = buf_q[rd_ptr_q];
        bus.busy      = (state_q == S_RUN);
        bus.done      = (state_q == S_DONE);
        bus.dbg_state = state_q;
        bus.dbg_occ   = occ_q;
    end
endmodule
